// File: rtl/bla_sub_seq.sv
// bla_sub_seq: multi-cycle borrow-lookahead subtractor, CHUNK bits per cycle.
// Optional macro BLA_SUB_SAT_EN: clamp the difference to zero on borrow-out.
module bla_sub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic             BIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH:0]   DIFF
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   diff_q, diff_d;

  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK-1:0] p, g, s;
  logic [CHUNK:0]   c;
  logic             bout;
  logic             accept;

  // Select the operand chunk addressed by the chunk counter.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IW'(k)) begin
        ca = a_q[k*CHUNK +: CHUNK];
        cb = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // Subtract as a + ~b + ~borrow with a carry lookahead inside the chunk.
  always_comb begin
    p    = ca ^ ~cb;
    g    = ca & ~cb;
    c    = '0;
    c[0] = ~br_q;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s    = p ^ c[CHUNK-1:0];
    bout = ~c[CHUNK];
  end

  // Next-state, datapath update and handshake decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    br_d      = br_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        accept   = IN_VALID;
      end
      CALC: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IW'(k)) begin
            diff_d[k*CHUNK +: CHUNK] = s;
          end
        end
        br_d  = bout;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          diff_d[WIDTH] = bout;
`ifdef BLA_SUB_SAT_EN
          if (bout) begin
            diff_d[WIDTH-1:0] = '0;
          end
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        OUT_VALID = 1'b1;
        IN_READY  = OUT_READY;
        if (OUT_READY) begin
          if (IN_VALID) begin
            accept = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture shared by IDLE and the back-to-back DONE path.
    if (accept) begin
      a_d     = IN1;
      b_d     = IN2;
      br_d    = BIN;
      idx_d   = '0;
      diff_d  = '0;
      state_d = CALC;
    end
  end

  assign DIFF = diff_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
    end
  end

endmodule

// File: tb/tb_bla_sub_seq.sv
// tb_bla_sub_seq: randomized self-checking bench for bla_sub_seq.
// Reference is plain integer subtraction reduced modulo 2^(W+1).
module tb_bla_sub_seq;

  localparam int W = 8;
  localparam int C = 4;
  localparam int N = W / C;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] IN1;
  logic [W-1:0] IN2;
  logic         BIN;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W:0]   DIFF;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bla_sub_seq #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN1      (IN1),
    .IN2      (IN2),
    .BIN      (BIN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .DIFF     (DIFF)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic bin);
    int d;
    logic [W:0] r;
    d = int'(a) - int'(b) - int'(bin);
    r = d[W:0];
`ifdef BLA_SUB_SAT_EN
    if (d < 0) r = {1'b1, {W{1'b0}}};
`endif
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_one(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic bin,
                         input string tag);
    chk({tag, ":rdy"}, 32'(IN_READY), 32'd1);
    IN1 = a;
    IN2 = b;
    BIN = bin;
    IN_VALID = 1'b1;
    OUT_READY = 1'b0;
    tick();
    IN_VALID = 1'b0;
    IN1 = W'($urandom);
    IN2 = W'($urandom);
    BIN = 1'($urandom);
    chk({tag, ":ov0"}, 32'(OUT_VALID), 32'd0);
    repeat (N - 1) begin
      tick();
      chk({tag, ":ov0"}, 32'(OUT_VALID), 32'd0);
    end
    tick();
    chk({tag, ":ov1"}, 32'(OUT_VALID), 32'd1);
    chk({tag, ":diff"}, 32'(DIFF), 32'(model(a, b, bin)));
    tick();
    chk({tag, ":hold"}, 32'(OUT_VALID), 32'd1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk({tag, ":ret"}, 32'(OUT_VALID), 32'd0);
    chk({tag, ":idle"}, 32'(IN_READY), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sa [16];
    logic [W-1:0] sb [16];
    logic         sc [16];
    logic [W:0]   held;
    logic [W-1:0] na, nb;
    logic         nc;

    RST_N = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    IN1 = '0;
    IN2 = '0;
    BIN = 1'b0;
    tick();
    tick();
    chk("rst_ov", 32'(OUT_VALID), 32'd0);
    chk("rst_rdy", 32'(IN_READY), 32'd1);
    chk("rst_diff", 32'(DIFF), 32'd0);
    RST_N = 1'b1;
    tick();

    run_one(8'h5A, 8'h3C, 1'b0, "d5a3c");
    run_one(8'h10, 8'h20, 1'b0, "d1020");
    run_one(8'h00, 8'h00, 1'b1, "d0000b");
    run_one(8'hFF, 8'hFF, 1'b0, "dffff");
    run_one(8'hFF, 8'h00, 1'b1, "dff00b");
    run_one(8'h00, 8'hFF, 1'b1, "d00ffb");
    run_one(8'h08, 8'h08, 1'b1, "d0808b");

    for (int i = 0; i < 12; i++) begin
      run_one(W'($urandom), W'($urandom), 1'($urandom), "rnd");
    end

    // backpressure
    IN1 = 8'h77;
    IN2 = 8'h23;
    BIN = 1'b1;
    IN_VALID = 1'b1;
    OUT_READY = 1'b0;
    tick();
    repeat (N) tick();
    held = model(8'h77, 8'h23, 1'b1);
    chk("bp_ov", 32'(OUT_VALID), 32'd1);
    chk("bp_diff", 32'(DIFF), 32'(held));
    for (int i = 0; i < 5; i++) begin
      IN1 = W'($urandom);
      IN2 = W'($urandom);
      tick();
      chk("bp_hold_diff", 32'(DIFF), 32'(held));
      chk("bp_hold_ov", 32'(OUT_VALID), 32'd1);
      chk("bp_hold_rdy", 32'(IN_READY), 32'd0);
    end
    na = W'($urandom);
    nb = W'($urandom);
    nc = 1'($urandom);
    IN1 = na;
    IN2 = nb;
    BIN = nc;
    OUT_READY = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    chk("bp_next_ov0", 32'(OUT_VALID), 32'd0);
    repeat (N - 1) begin
      tick();
      chk("bp_next_ov0", 32'(OUT_VALID), 32'd0);
    end
    tick();
    chk("bp_next_ov1", 32'(OUT_VALID), 32'd1);
    chk("bp_next_diff", 32'(DIFF), 32'(model(na, nb, nc)));
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("bp_idle", 32'(IN_READY), 32'd1);

    // back-to-back stream
    for (int i = 0; i < 16; i++) begin
      sa[i] = W'($urandom);
      sb[i] = W'($urandom);
      sc[i] = 1'($urandom);
    end
    IN1 = sa[0];
    IN2 = sb[0];
    BIN = sc[0];
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 15) begin
        IN1 = sa[i+1];
        IN2 = sb[i+1];
        BIN = sc[i+1];
      end else begin
        IN_VALID = 1'b0;
      end
      chk("st_ov0", 32'(OUT_VALID), 32'd0);
      repeat (N - 1) begin
        tick();
        chk("st_ov0", 32'(OUT_VALID), 32'd0);
      end
      tick();
      chk("st_ov1", 32'(OUT_VALID), 32'd1);
      chk("st_rdy", 32'(IN_READY), 32'd1);
      chk("st_diff", 32'(DIFF), 32'(model(sa[i], sb[i], sc[i])));
    end
    tick();
    OUT_READY = 1'b0;
    chk("st_idle_ov", 32'(OUT_VALID), 32'd0);
    chk("st_idle_rdy", 32'(IN_READY), 32'd1);

    // reset in the middle of a calculation
    IN1 = 8'hAB;
    IN2 = 8'h12;
    BIN = 1'b0;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("mrst_ov", 32'(OUT_VALID), 32'd0);
    chk("mrst_diff", 32'(DIFF), 32'd0);
    chk("mrst_rdy", 32'(IN_READY), 32'd1);
    repeat (N + 1) begin
      tick();
      chk("mrst_quiet", 32'(OUT_VALID), 32'd0);
    end
    run_one(8'h5A, 8'h3C, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
